// File: rtl/tomasulo_cdb_arb.sv
// tomasulo_cdb_arb: credit-throttled per-unit result queues, round-robin onto the CDB (optional macro TOMASULO_CDB_ARB_BYPASS_EN)
package tomasulo_pkg;
   typedef struct packed {
      logic [5:0]  tag;
      logic [31:0] data;
   } cdb_t;
endpackage

module tomasulo_cdb_arb
   import tomasulo_pkg::*;
#(
   parameter int N_SRC   = 2,
   parameter int Q_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] iss_vld,
   output logic [N_SRC-1:0] iss_rdy,
   input  logic [N_SRC-1:0] src_vld,
   input  cdb_t             src_cdb [N_SRC],
   output logic             cdb_vld_r,
   output cdb_t             cdb_r
);
   localparam int CW = $clog2(Q_DEPTH + 1);
   localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
   localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   cdb_t             mem_q    [N_SRC][Q_DEPTH];
   cdb_t             mem_d    [N_SRC][Q_DEPTH];
   logic [PW-1:0]    wr_ptr_q [N_SRC];
   logic [PW-1:0]    wr_ptr_d [N_SRC];
   logic [PW-1:0]    rd_ptr_q [N_SRC];
   logic [PW-1:0]    rd_ptr_d [N_SRC];
   logic [CW-1:0]    cnt_q    [N_SRC];
   logic [CW-1:0]    cnt_d    [N_SRC];
   logic [CW-1:0]    ctr_q    [N_SRC];
   logic [CW-1:0]    ctr_d    [N_SRC];
   logic [SW-1:0]    rr_q, rr_d;
   logic             cdb_vld_q, cdb_vld_d;
   cdb_t             cdb_q, cdb_d;
   logic [N_SRC-1:0] cand, push, pop, grt;
   logic [SW-1:0]    win;
   logic             gnt, byp;
   cdb_t             head;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (int'(p) == Q_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   // Candidates, round-robin winner starting after rr_q, and the payload it sends
   always_comb begin
      for (int u = 0; u < N_SRC; u++)
`ifdef TOMASULO_CDB_ARB_BYPASS_EN
         cand[u] = (cnt_q[u] != '0) || src_vld[u];
`else
         cand[u] = cnt_q[u] != '0;
`endif
      win = '0;
      gnt = 1'b0;
      for (int i = 1; i <= N_SRC; i++)
         if (!gnt && cand[(int'(rr_q) + i) % N_SRC]) begin
            gnt = 1'b1;
            win = SW'((int'(rr_q) + i) % N_SRC);
         end
`ifdef TOMASULO_CDB_ARB_BYPASS_EN
      byp = gnt && (cnt_q[win] == '0);
`else
      byp = 1'b0;
`endif
      head = byp ? src_cdb[win] : mem_q[win][rd_ptr_q[win]];
      for (int u = 0; u < N_SRC; u++) begin
         grt[u]  = gnt && (win == SW'(u));
         pop[u]  = grt[u] && !byp;
         push[u] = src_vld[u] && !(grt[u] && byp);
      end
   end

   // Queue, credit, pointer and CDB next-state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ctr_d    = ctr_q;
      for (int u = 0; u < N_SRC; u++) begin
         if (push[u]) begin
            mem_d[u][wr_ptr_q[u]] = src_cdb[u];
            wr_ptr_d[u] = nxt(wr_ptr_q[u]);
         end
         if (pop[u])
            rd_ptr_d[u] = nxt(rd_ptr_q[u]);
         cnt_d[u]   = cnt_q[u] + CW'(push[u]) - CW'(pop[u]);
         ctr_d[u]   = ctr_q[u] + CW'(grt[u]) - CW'(iss_vld[u]);
         iss_rdy[u] = ctr_q[u] != '0;
      end
      rr_d      = gnt ? win : rr_q;
      cdb_vld_d = gnt;
      cdb_d     = gnt ? head : cdb_q;
   end

   // Control state with synchronous reset; unit 0 wins first after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '{default: '0};
         rd_ptr_q  <= '{default: '0};
         cnt_q     <= '{default: '0};
         ctr_q     <= '{default: CW'(Q_DEPTH)};
         rr_q      <= SW'(N_SRC - 1);
         cdb_vld_q <= 1'b0;
         cdb_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ctr_q     <= ctr_d;
         rr_q      <= rr_d;
         cdb_vld_q <= cdb_vld_d;
         cdb_q     <= cdb_d;
      end
   end

   // Queue storage needs no reset; occupancy counts decide what is valid
   always_ff @(posedge clk)
      mem_q <= mem_d;

   // Issue without credit, or a push into a full queue that is not also popping, is a protocol error
   always_ff @(posedge clk)
      if (!rst)
         for (int u = 0; u < N_SRC; u++) begin
            assert (!(iss_vld[u] && ctr_q[u] == '0));
            assert (!(push[u] && !pop[u] && cnt_q[u] == CW'(Q_DEPTH)));
         end

   assign cdb_vld_r = cdb_vld_q;
   assign cdb_r     = cdb_q;
endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// tb_tomasulo_cdb_arb: directed checks of reset, latency, contention order, credits and mid-drain reset
module tb_tomasulo_cdb_arb;
   import tomasulo_pkg::*;
`ifdef TOMASULO_CDB_ARB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] iss_vld = '0;
   logic [1:0] src_vld = '0;
   logic [1:0] iss_rdy;
   cdb_t       src_cdb [2];
   logic       cdb_vld_r;
   cdb_t       cdb_r;
   int         n_vec = 0;
   int         n_err = 0;
   logic [5:0] got [$];
   int         first_t, last_t, nv;
   logic [5:0] exp_tag;

   always #5 clk = ~clk;

   tomasulo_cdb_arb #(.N_SRC(2), .Q_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_rdy(iss_rdy),
      .src_vld(src_vld), .src_cdb(src_cdb), .cdb_vld_r(cdb_vld_r), .cdb_r(cdb_r)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int u, input logic [5:0] tag);
      src_cdb[u] = '{tag: tag, data: {26'd0, tag}};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      iss_vld = '0;
      src_vld = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      src_cdb = '{default: '0};
      do_reset();
      check("rst_iss_rdy", iss_rdy, 2'b11);
      check("rst_cdb_vld", cdb_vld_r, 0);
      check("rst_cdb", cdb_r, 0);
      check("rst_ctr0", dut.ctr_q[0], 4);
      check("rst_ctr1", dut.ctr_q[1], 4);
      // single result latency and hold when idle
      iss_vld = 2'b01;
      tick();
      iss_vld = '0;
      check("single_ctr_taken", dut.ctr_q[0], 3);
      put(0, 6'h03);
      src_vld = 2'b01;
      for (int k = 1; k <= 3; k++) begin
         tick();
         src_vld = '0;
         check($sformatf("single_vld_k%0d", k), cdb_vld_r, k == LAT);
      end
      check("single_tag_hold", cdb_r.tag, 6'h03);
      check("single_data_hold", cdb_r.data, 32'h3);
      check("single_ctr_back", dut.ctr_q[0], 4);
      // contention: both units push four times, expect strict alternation with no gaps
      do_reset();
      iss_vld = 2'b11;
      repeat (4) tick();
      iss_vld = '0;
      check("cont_no_credit", iss_rdy, 2'b00);
      got.delete();
      first_t = -1;
      last_t = -1;
      for (int c = 0; c < 14; c++) begin
         if (c < 4) begin
            put(0, 6'(8'h10 + c));
            put(1, 6'(8'h20 + c));
         end
         src_vld = (c < 4) ? 2'b11 : 2'b00;
         tick();
         if (cdb_vld_r) begin
            got.push_back(cdb_r.tag);
            if (first_t < 0) first_t = c;
            last_t = c;
         end
      end
      src_vld = '0;
      check("cont_count", got.size(), 8);
      check("cont_no_gap", last_t - first_t, 7);
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         exp_tag = (i % 2 == 0) ? 6'(8'h10 + i / 2) : 6'(8'h20 + i / 2);
         check($sformatf("cont_order_%0d", i), got[i], exp_tag);
      end
      check("cont_credits_back", iss_rdy, 2'b11);
      // credits on unit 1
      do_reset();
      iss_vld = 2'b10;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 3) check("cred_rdy1_one_left", iss_rdy[1], 1'b1);
      end
      iss_vld = '0;
      check("cred_rdy1_empty", iss_rdy[1], 1'b0);
      check("cred_rdy0_untouched", iss_rdy[0], 1'b1);
      put(1, 6'h2A);
      src_vld = 2'b10;
      tick();
      src_vld = '0;
      check("cred_rdy1_after_push", iss_rdy[1], LAT == 1);
      tick();
      check("cred_rdy1_after_grant", iss_rdy[1], 1'b1);
      check("cred_u1_tag", cdb_r.tag, 6'h2A);
      // same-cycle issue and grant on unit 0 at ctr=1
      do_reset();
      iss_vld = 2'b01;
      repeat (3) tick();
      iss_vld = '0;
      check("same_ctr_one", dut.ctr_q[0], 1);
      check("same_rdy_before", iss_rdy[0], 1'b1);
      put(0, 6'h05);
      src_vld = 2'b01;
      tick();
      src_vld = '0;
      iss_vld = 2'b01;
      tick();
      iss_vld = '0;
      check("same_ctr_stays", dut.ctr_q[0], 1);
      check("same_rdy_stays", iss_rdy[0], 1'b1);
      check("same_vld", cdb_vld_r, LAT == 2);
      check("same_tag", cdb_r.tag, 6'h05);
      // reset in the middle of a drain
      do_reset();
      iss_vld = 2'b11;
      repeat (4) tick();
      iss_vld = '0;
      for (int c = 0; c < 4; c++) begin
         put(0, 6'(8'h30 + c));
         put(1, 6'(8'h38 + c));
         src_vld = 2'b11;
         tick();
      end
      src_vld = '0;
      check("drain_active", cdb_vld_r, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("drain_rst_vld", cdb_vld_r, 1'b0);
      nv = 0;
      repeat (5) begin
         tick();
         if (cdb_vld_r) nv++;
      end
      check("drain_no_vld", nv, 0);
      check("drain_ctr0", dut.ctr_q[0], 4);
      check("drain_ctr1", dut.ctr_q[1], 4);
      check("drain_rdy", iss_rdy, 2'b11);
      iss_vld = 2'b01;
      tick();
      iss_vld = '0;
      put(0, 6'h3C);
      src_vld = 2'b01;
      for (int k = 1; k <= 3; k++) begin
         tick();
         src_vld = '0;
         check($sformatf("post_rst_vld_k%0d", k), cdb_vld_r, k == LAT);
      end
      check("post_rst_tag", cdb_r.tag, 6'h3C);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
